// File: rtl/m_tile_mem_arbiter_pkg.sv
// Shared definitions for the maze tile RAM arbiter: geometry defaults,
// requester indices and FSM state encodings.
package m_tile_mem_arbiter_pkg;

  localparam int COLS_DEF      = 29;
  localparam int ROWS_DEF      = 15;
  localparam int AW_DEF        = 9;
  localparam int FOOD_INIT_DEF = 188;

  localparam logic [1:0] REQ_RENDER = 2'd0;
  localparam logic [1:0] REQ_LOOKUP = 2'd1;
  localparam logic [1:0] REQ_EAT    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_CLR  = 2'd2
  } state_t;

  // Round-robin successor of a granted requester index, modulo 3.
  function automatic logic [1:0] rr_next(input logic [1:0] k);
    return (k == REQ_EAT) ? REQ_RENDER : (k + 2'd1);
  endfunction

endpackage

// File: rtl/m_tile_mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker: the first active request at or
// after i_ptr (wrapping) wins.
module m_rr_pick3
  import m_tile_mem_arbiter_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_ptr,
  output logic       o_valid,
  output logic [1:0] o_idx,
  output logic [2:0] o_gnt
);

  logic [1:0] w_c0, w_c1, w_c2;

  // Search order rotated to start at the pointer.
  always_comb begin
    case (i_ptr)
      REQ_LOOKUP: begin w_c0 = REQ_LOOKUP; w_c1 = REQ_EAT;    w_c2 = REQ_RENDER; end
      REQ_EAT:    begin w_c0 = REQ_EAT;    w_c1 = REQ_RENDER; w_c2 = REQ_LOOKUP; end
      default:    begin w_c0 = REQ_RENDER; w_c1 = REQ_LOOKUP; w_c2 = REQ_EAT;    end
    endcase
  end

  // First requesting candidate in rotated order.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 2'd0;
    o_gnt   = 3'b000;
    if (i_req[w_c0]) begin
      o_valid = 1'b1;
      o_idx   = w_c0;
    end else if (i_req[w_c1]) begin
      o_valid = 1'b1;
      o_idx   = w_c1;
    end else if (i_req[w_c2]) begin
      o_valid = 1'b1;
      o_idx   = w_c2;
    end else begin
      o_valid = 1'b0;
    end
    if (o_valid) begin
      o_gnt = 3'b001 << o_idx;
    end else begin
      o_gnt = 3'b000;
    end
  end

endmodule

// File: rtl/m_tile_mem_arbiter.sv
// Arbitrates the 1-bit maze tile RAM between render, lookup and eat (RMW) requesters.
// Optional food counter enabled by defining TILE_FOOD_COUNT_EN.
module m_tile_mem_arbiter
  import m_tile_mem_arbiter_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int AW        = AW_DEF,
  parameter int FOOD_INIT = FOOD_INIT_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [2:0]    req,
  input  logic [4:0]    x0,
  input  logic [4:0]    x1,
  input  logic [4:0]    x2,
  input  logic [3:0]    y0,
  input  logic [3:0]    y1,
  input  logic [3:0]    y2,
  output logic [2:0]    gnt,
  output logic [2:0]    rvalid,
  output logic          rdata,
  output logic          eat_hit,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wren,
  output logic          mem_wdata,
  input  logic          mem_q,
  output logic [AW-1:0] food_left,
  output logic          all_eaten
);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt, r_k, w_k_nxt;
  logic          r_oor, w_oor_nxt;
  logic [2:0]    r_gnt, w_gnt_nxt, r_rvalid, w_rvalid_nxt;
  logic          r_rdata, w_rdata_nxt, r_eat_hit, w_eat_hit_nxt, r_wren, w_wren_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt, w_sel_addr;
  logic          w_pick_valid, w_sel_oor;
  logic [1:0]    w_pick_idx;
  logic [2:0]    w_pick_gnt;
  logic [4:0]    w_x;
  logic [3:0]    w_y;

  m_rr_pick3 u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx),
    .o_gnt   (w_pick_gnt)
  );

  // Coordinates of the candidate winner and their linear address.
  always_comb begin
    case (w_pick_idx)
      REQ_LOOKUP: begin w_x = x1; w_y = y1; end
      REQ_EAT:    begin w_x = x2; w_y = y2; end
      default:    begin w_x = x0; w_y = y0; end
    endcase
    w_sel_oor  = (int'(w_x) >= COLS) || (int'(w_y) >= ROWS);
    w_sel_addr = AW'(int'(w_y) * COLS + int'(w_x));
  end

  // Next-state and next-output logic; mem_addr doubles as the RAM's address
  // register, so mem_q is valid in the RD_WAIT cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_k_nxt       = r_k;
    w_oor_nxt     = r_oor;
    w_addr_nxt    = r_addr;
    w_gnt_nxt     = 3'b000;
    w_rvalid_nxt  = 3'b000;
    w_rdata_nxt   = 1'b0;
    w_eat_hit_nxt = 1'b0;
    w_wren_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt   = w_pick_gnt;
          w_k_nxt     = w_pick_idx;
          w_oor_nxt   = w_sel_oor;
          w_ptr_nxt   = rr_next(w_pick_idx);
          w_state_nxt = S_RD_WAIT;
          if (!w_sel_oor) begin
            w_addr_nxt = w_sel_addr;
          end else begin
            w_addr_nxt = r_addr;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (r_oor) begin
          w_rvalid_nxt = 3'b001 << r_k;
          w_rdata_nxt  = 1'b1;
          w_state_nxt  = S_IDLE;
        end else if ((r_k == REQ_EAT) && mem_q) begin
          w_wren_nxt    = 1'b1;
          w_rvalid_nxt  = 3'b100;
          w_rdata_nxt   = 1'b1;
          w_eat_hit_nxt = 1'b1;
          w_state_nxt   = S_WR_CLR;
        end else begin
          w_rvalid_nxt = 3'b001 << r_k;
          w_rdata_nxt  = mem_q;
          w_state_nxt  = S_IDLE;
        end
      end
      S_WR_CLR: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= REQ_RENDER;
      r_k       <= REQ_RENDER;
      r_oor     <= 1'b0;
      r_addr    <= {AW{1'b0}};
      r_gnt     <= 3'b000;
      r_rvalid  <= 3'b000;
      r_rdata   <= 1'b0;
      r_eat_hit <= 1'b0;
      r_wren    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_k       <= w_k_nxt;
      r_oor     <= w_oor_nxt;
      r_addr    <= w_addr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_eat_hit <= w_eat_hit_nxt;
      r_wren    <= w_wren_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rvalid    = r_rvalid;
  assign rdata     = r_rdata;
  assign eat_hit   = r_eat_hit;
  assign mem_addr  = r_addr;
  // A reset landing on the clear cycle must suppress the pending write.
  assign mem_wren  = r_wren & ~reset;
  assign mem_wdata = 1'b0;

`ifdef TILE_FOOD_COUNT_EN
  logic [AW-1:0] r_food_left;

  // Remaining food, saturating at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_food_left <= AW'(FOOD_INIT);
    end else if (r_eat_hit && (r_food_left != {AW{1'b0}})) begin
      r_food_left <= r_food_left - {{(AW-1){1'b0}}, 1'b1};
    end else begin
      r_food_left <= r_food_left;
    end
  end

  assign food_left = r_food_left;
  assign all_eaten = (r_food_left == {AW{1'b0}});
`else
  assign food_left = {AW{1'b0}};
  assign all_eaten = 1'b0;
`endif

endmodule

// File: tb/tb_m_tile_mem_arbiter.sv
// Directed self-checking bench for m_tile_mem_arbiter with a combinational-read RAM model.
module tb_m_tile_mem_arbiter;

  localparam int AW = 9;
  localparam int FI = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [4:0]    x0, x1, x2;
  logic [3:0]    y0, y1, y2;
  logic [2:0]    gnt, rvalid;
  logic          rdata, eat_hit, mem_wren, mem_wdata, mem_q, all_eaten;
  logic [AW-1:0] mem_addr, food_left;
  logic          ram [0:511];

  int n_checks = 0;
  int n_errors = 0;

  m_tile_mem_arbiter #(.COLS(29), .ROWS(15), .AW(AW), .FOOD_INIT(FI)) dut (
    .clock(clock), .reset(reset), .req(req),
    .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .eat_hit(eat_hit),
    .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata), .mem_q(mem_q),
    .food_left(food_left), .all_eaten(all_eaten)
  );

  always #5 clock = ~clock;

  assign mem_q = ram[mem_addr];

  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 3'b000;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic set_xy(input int k, input logic [4:0] x, input logic [3:0] y);
    case (k)
      0: begin x0 = x; y0 = y; end
      1: begin x1 = x; y1 = y; end
      default: begin x2 = x; y2 = y; end
    endcase
  endtask

  // One full transaction for requester k, starting and ending at a negedge in IDLE.
  task automatic txn(input string tag, input int k, input logic [4:0] x, input logic [3:0] y,
                     input logic addr_chk, input logic [AW-1:0] exp_addr,
                     input logic exp_rdata, input logic exp_hit);
    logic [2:0] eg;
    eg = 3'b001 << k;
    set_xy(k, x, y);
    req = eg;
    step();
    chk({tag, "_gnt"}, gnt, eg);
    chk({tag, "_wren0"}, mem_wren, 1'b0);
    if (addr_chk) chk({tag, "_addr"}, mem_addr, exp_addr);
    req = 3'b000;
    step();
    chk({tag, "_gnt_off"}, gnt, 3'b000);
    chk({tag, "_rvalid"}, rvalid, eg);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_eat"}, eat_hit, exp_hit);
    chk({tag, "_wren"}, mem_wren, exp_hit);
    if (exp_hit) begin
      chk({tag, "_wr_addr"}, mem_addr, exp_addr);
      chk({tag, "_wdata"}, mem_wdata, 1'b0);
      step();
      chk({tag, "_rvalid_off"}, rvalid, 3'b000);
      chk({tag, "_wren_off"}, mem_wren, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 1'b0;
    x0 = 5'd0; x1 = 5'd0; x2 = 5'd0;
    y0 = 4'd0; y1 = 4'd0; y2 = 4'd0;
    @(negedge clock);
    do_reset();

    chk("rst_gnt", gnt, 3'b000);
    chk("rst_rvalid", rvalid, 3'b000);
    chk("rst_rdata", rdata, 1'b0);
    chk("rst_eat", eat_hit, 1'b0);
    chk("rst_addr", mem_addr, 9'd0);
    chk("rst_wren", mem_wren, 1'b0);
`ifdef TILE_FOOD_COUNT_EN
    chk("rst_food", food_left, 9'd2);
    chk("rst_all_eaten", all_eaten, 1'b0);
`else
    chk("rst_food", food_left, 9'd0);
    chk("rst_all_eaten", all_eaten, 1'b0);
`endif

    // Render read at (3,2) -> address 61
    ram[61] = 1'b1;
    txn("t1", 0, 5'd3, 4'd2, 1'b1, 9'd61, 1'b1, 1'b0);
    txn("t1_lookup0", 1, 5'd4, 4'd2, 1'b1, 9'd62, 1'b0, 1'b0);

    // All three requesting from reset: rotation 001,010,100,001
    x0 = 5'd0; y0 = 4'd0; x1 = 5'd0; y1 = 4'd0; x2 = 5'd0; y2 = 4'd0;
    reset = 1'b1;
    req   = 3'b111;
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("t2_g0", gnt, 3'b001);
    step();
    chk("t2_gap", gnt, 3'b000);
    chk("t2_rv0", rvalid, 3'b001);
    step();
    chk("t2_g1", gnt, 3'b010);
    step();
    step();
    chk("t2_g2", gnt, 3'b100);
    step();
    chk("t2_nohit", eat_hit, 1'b0);
    step();
    chk("t2_g3", gnt, 3'b001);
    req = 3'b000;
    step();

    // Eat food at (5,4) -> address 121, then the same cell again
    do_reset();
    ram[121] = 1'b1;
    txn("t3_hit", 2, 5'd5, 4'd4, 1'b1, 9'd121, 1'b1, 1'b1);
    chk("t3_cleared", ram[121], 1'b0);
    txn("t3_miss", 2, 5'd5, 4'd4, 1'b1, 9'd121, 1'b0, 1'b0);

    // Range boundaries
    ram[434] = 1'b1;
    txn("t4_edge", 1, 5'd28, 4'd14, 1'b1, 9'd434, 1'b1, 1'b0);
    ram[116] = 1'b0;
    txn("t4_oor_x", 1, 5'd29, 4'd3, 1'b0, 9'd0, 1'b1, 1'b0);
    ram[435] = 1'b1;
    txn("t4_oor_y", 2, 5'd0, 4'd15, 1'b0, 9'd0, 1'b1, 1'b0);
    chk("t4_oor_keep", ram[435], 1'b1);

    // Reset during the clear cycle drops the write and resets the pointer
    do_reset();
    txn("t5_pre", 0, 5'd0, 4'd0, 1'b1, 9'd0, 1'b0, 1'b0);
    ram[121] = 1'b1;
    set_xy(2, 5'd5, 4'd4);
    req = 3'b100;
    step();
    chk("t5_gnt", gnt, 3'b100);
    req = 3'b000;
    step();
    chk("t5_wren_pre", mem_wren, 1'b1);
    reset = 1'b1;
    #1;
    chk("t5_wren_rst", mem_wren, 1'b0);
    step();
    chk("t5_gnt0", gnt, 3'b000);
    chk("t5_rv0", rvalid, 3'b000);
    chk("t5_eat0", eat_hit, 1'b0);
    chk("t5_addr0", mem_addr, 9'd0);
    chk("t5_nowrite", ram[121], 1'b1);
    reset = 1'b0;
    req   = 3'b011;
    step();
    chk("t5_next", gnt, 3'b001);
    req = 3'b000;
    repeat (2) step();

    // Food counter
    do_reset();
    ram[121] = 1'b1;
    txn("t6_a", 2, 5'd5, 4'd4, 1'b1, 9'd121, 1'b1, 1'b1);
`ifdef TILE_FOOD_COUNT_EN
    chk("t6_food1", food_left, 9'd1);
    chk("t6_ae1", all_eaten, 1'b0);
`else
    chk("t6_food_off", food_left, 9'd0);
    chk("t6_ae_off", all_eaten, 1'b0);
`endif
    ram[121] = 1'b1;
    txn("t6_b", 2, 5'd5, 4'd4, 1'b1, 9'd121, 1'b1, 1'b1);
    ram[121] = 1'b1;
    txn("t6_c", 2, 5'd5, 4'd4, 1'b1, 9'd121, 1'b1, 1'b1);
`ifdef TILE_FOOD_COUNT_EN
    chk("t6_food0", food_left, 9'd0);
    chk("t6_ae", all_eaten, 1'b1);
`else
    chk("t6_food_off2", food_left, 9'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
